// File: rtl/temp_comparator_pkg.sv
// Shared definitions for the temperature comparator and the AC controller that consumes temp_comp.
package temp_comparator_pkg;

    localparam logic [1:0] TC_IDLE = 2'b00;
    localparam logic [1:0] TC_COLD = 2'b01;
    localparam logic [1:0] TC_HOT  = 2'b10;
    localparam logic [1:0] TC_RSVD = 2'b11;

    typedef enum logic {
        ACCUM = 1'b0,
        EVAL  = 1'b1
    } state_e;

endpackage

// File: rtl/temp_window_avg.sv
// Block averager: sums 2**AVG_LOG2 handshaked samples, then holds one EVAL cycle exposing the average.
module temp_window_avg
    import temp_comparator_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] temp_sample,
    output logic              sample_ready,
    output logic              window_done,
    output logic [DATA_W-1:0] avg
);

    localparam int SUM_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << AVG_LOG2) - 1);

    state_e             state_q, state_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;

    assign sample_ready = (state_q == ACCUM);
    assign accept       = sample_valid && sample_ready;
    assign window_done  = (state_q == EVAL);
    // Truncating divide by the window length: drop the low AVG_LOG2 bits.
    assign avg          = sum_q[SUM_W-1:AVG_LOG2];

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    sum_d = sum_q + SUM_W'(temp_sample);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                state_d = ACCUM;
                sum_d   = '0;
                cnt_d   = '0;
            end
            default: begin
                state_d = ACCUM;
                sum_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/temp_comparator.sv
// Averaged setpoint comparator with hysteresis and window-count debounce producing the AC temp_comp code.
module temp_comparator
    import temp_comparator_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 2,
    parameter int HYST     = 2,
    parameter int DEBOUNCE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] temp_sample,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] setpoint,
    output logic [1:0]        temp_comp,
    output logic [DATA_W-1:0] avg_temp,
    output logic              comp_valid
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);
    localparam logic [DATA_W:0]   HYST_X   = (DATA_W + 1)'(HYST);
    localparam logic [DB_W-1:0]   DB_LIMIT = DB_W'(DEBOUNCE);

    logic              window_done;
    logic [DATA_W-1:0] win_avg;

    logic [1:0]        temp_comp_q, temp_comp_d;
    logic [1:0]        pending_q, pending_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [DATA_W-1:0] avg_temp_q, avg_temp_d;
    logic              comp_valid_q, comp_valid_d;

    logic [DATA_W:0]   avg_x, sp_x;
    logic [DB_W-1:0]   db_next;
    logic              hot, cold;
    logic [1:0]        candidate;

    temp_window_avg #(
        .DATA_W   (DATA_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_window_avg (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .temp_sample  (temp_sample),
        .sample_ready (sample_ready),
        .window_done  (window_done),
        .avg          (win_avg)
    );

    // One extra bit keeps setpoint+HYST and avg+HYST from wrapping near full scale.
    always_comb begin
        avg_x = {1'b0, win_avg};
        sp_x  = {1'b0, setpoint};
        hot   = avg_x > (sp_x + HYST_X);
        cold  = (avg_x + HYST_X) < sp_x;
        if (temp_comp_q == TC_HOT && avg_x > sp_x) begin
            candidate = TC_HOT;
        end else if (temp_comp_q == TC_COLD && avg_x < sp_x) begin
            candidate = TC_COLD;
        end else if (hot) begin
            candidate = TC_HOT;
        end else if (cold) begin
            candidate = TC_COLD;
        end else begin
            candidate = TC_IDLE;
        end
    end

    always_comb begin
        temp_comp_d  = temp_comp_q;
        pending_d    = pending_q;
        db_cnt_d     = db_cnt_q;
        avg_temp_d   = avg_temp_q;
        comp_valid_d = window_done;
        db_next      = db_cnt_q;
        if (window_done) begin
            avg_temp_d = win_avg;
            if (candidate == temp_comp_q) begin
                db_next = '0;
            end else if (candidate == pending_q) begin
                db_next = db_cnt_q + DB_W'(1);
            end else begin
                pending_d = candidate;
                db_next   = DB_W'(1);
            end
            // A candidate that has agreed for DEBOUNCE windows becomes the output.
            if (db_next == DB_LIMIT) begin
                temp_comp_d = candidate;
                db_cnt_d    = '0;
            end else begin
                db_cnt_d    = db_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            temp_comp_q  <= TC_IDLE;
            pending_q    <= TC_IDLE;
            db_cnt_q     <= '0;
            avg_temp_q   <= '0;
            comp_valid_q <= 1'b0;
        end else begin
            temp_comp_q  <= temp_comp_d;
            pending_q    <= pending_d;
            db_cnt_q     <= db_cnt_d;
            avg_temp_q   <= avg_temp_d;
            comp_valid_q <= comp_valid_d;
        end
    end

    assign temp_comp  = temp_comp_q;
    assign avg_temp   = avg_temp_q;
    assign comp_valid = comp_valid_q;

endmodule

// File: tb/tb_temp_comparator.sv
// Directed bench for temp_comparator: windowed averages, hysteresis, debounce, reset and handshake gaps.
module tb_temp_comparator;

    logic       clk;
    logic       reset;
    logic       sample_valid;
    logic [7:0] temp_sample;
    logic       sample_ready;
    logic [7:0] setpoint;
    logic [1:0] temp_comp;
    logic [7:0] avg_temp;
    logic       comp_valid;

    int n_tests;
    int n_fail;

    temp_comparator #(
        .DATA_W   (8),
        .AVG_LOG2 (2),
        .HYST     (2),
        .DEBOUNCE (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .temp_sample  (temp_sample),
        .sample_ready (sample_ready),
        .setpoint     (setpoint),
        .temp_comp    (temp_comp),
        .avg_temp     (avg_temp),
        .comp_valid   (comp_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input integer obs, input integer exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present one sample and hold it until the handshake completes (bounded).
    task automatic send(input logic [7:0] v);
        int   tries;
        logic hs;
        tries = 0;
        hs    = 1'b0;
        sample_valid = 1'b1;
        temp_sample  = v;
        while (!hs && tries < 16) begin
            hs = sample_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!hs) check("send_timeout", 0, 1);
        sample_valid = 1'b0;
    endtask

    task automatic run_window(input string tag, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input integer exp_avg, input integer exp_tc);
        send(a);
        send(b);
        send(c);
        send(d);
        @(negedge clk);
        check({tag, "_ready_eval"}, sample_ready, 0);
        check({tag, "_cv_early"}, comp_valid, 0);
        @(negedge clk);
        check({tag, "_cv"}, comp_valid, 1);
        check({tag, "_avg"}, avg_temp, exp_avg);
        check({tag, "_tc"}, temp_comp, exp_tc);
        check({tag, "_ready_back"}, sample_ready, 1);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         acc_sum;
        int         acc_cnt;
        int         prev_cv;
        n_tests      = 0;
        n_fail       = 0;
        reset        = 1'b1;
        sample_valid = 1'b0;
        temp_sample  = 8'd0;
        setpoint     = 8'd100;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_tc", temp_comp, 0);
        check("rst_avg", avg_temp, 0);
        check("rst_cv", comp_valid, 0);
        check("rst_ready", sample_ready, 1);

        // 1: hot input debounces over three windows
        run_window("t1_w1", 110, 110, 110, 110, 110, 2'b00);
        run_window("t1_w2", 110, 110, 110, 110, 110, 2'b00);
        run_window("t1_w3", 110, 110, 110, 110, 110, 2'b10);
        @(negedge clk);
        check("t1_cv_one_cycle", comp_valid, 0);

        // 2: hysteresis hold at 101, release at 100
        run_window("t2_h1", 101, 101, 101, 101, 101, 2'b10);
        run_window("t2_h2", 101, 101, 101, 101, 101, 2'b10);
        run_window("t2_r1", 100, 100, 100, 100, 100, 2'b10);
        run_window("t2_r2", 100, 100, 100, 100, 100, 2'b10);
        run_window("t2_r3", 100, 100, 100, 100, 100, 2'b00);

        // 3: interrupting hot window restarts the cold debounce
        run_window("t3_w1", 97, 97, 97, 97, 97, 2'b00);
        run_window("t3_w2", 97, 97, 97, 97, 97, 2'b00);
        run_window("t3_w3", 103, 103, 103, 103, 103, 2'b00);
        run_window("t3_w4", 97, 97, 97, 97, 97, 2'b00);
        run_window("t3_w5", 97, 97, 97, 97, 97, 2'b00);
        run_window("t3_w6", 97, 97, 97, 97, 97, 2'b01);

        // 4a: full-scale sum truncates without overflow
        run_window("t4_trunc", 0, 255, 255, 255, 191, 2'b01);

        // 5: reset mid-window, with a sample offered during reset
        send(200);
        send(200);
        reset        = 1'b1;
        sample_valid = 1'b1;
        temp_sample  = 8'd50;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        sample_valid = 1'b0;
        check("t5_tc", temp_comp, 0);
        check("t5_avg", avg_temp, 0);
        check("t5_cv", comp_valid, 0);
        check("t5_ready", sample_ready, 1);
        run_window("t5_win", 120, 120, 120, 120, 120, 2'b00);

        // 4b: comparisons near the rails must not wrap
        setpoint = 8'd254;
        run_window("t4_hi1", 255, 255, 255, 255, 255, 2'b00);
        run_window("t4_hi2", 255, 255, 255, 255, 255, 2'b00);
        run_window("t4_hi3", 255, 255, 255, 255, 255, 2'b00);
        setpoint = 8'd255;
        run_window("t4_sp1", 254, 254, 254, 254, 254, 2'b00);
        run_window("t4_sp2", 254, 254, 254, 254, 254, 2'b00);
        run_window("t4_sp3", 254, 254, 254, 254, 254, 2'b00);
        setpoint = 8'd0;
        run_window("t4_lo1", 0, 0, 0, 0, 0, 2'b00);
        run_window("t4_lo2", 0, 0, 0, 0, 0, 2'b00);
        run_window("t4_lo3", 0, 0, 0, 0, 0, 2'b00);

        // 6: random valid gaps; only handshaked samples are averaged
        setpoint = 8'd100;
        acc_sum  = 0;
        acc_cnt  = 0;
        prev_cv  = 0;
        for (int cyc = 0; cyc < 220; cyc++) begin
            @(negedge clk);
            check("t6_not_rsvd", (temp_comp == 2'b11), 0);
            if (comp_valid) begin
                check("t6_cv_single", prev_cv, 0);
                if (exp_q.size() == 0) begin
                    check("t6_unexpected_cv", 1, 0);
                end else begin
                    check("t6_avg", avg_temp, exp_q.pop_front());
                end
            end
            prev_cv = comp_valid;
            if (cyc < 200) begin
                sample_valid = ($urandom_range(0, 2) != 0);
                temp_sample  = 8'($urandom_range(80, 130));
            end else begin
                sample_valid = 1'b0;
            end
            if (sample_valid && sample_ready) begin
                acc_sum += temp_sample;
                acc_cnt++;
                if (acc_cnt == 4) begin
                    exp_q.push_back(8'(acc_sum / 4));
                    acc_sum = 0;
                    acc_cnt = 0;
                end
            end
        end
        check("t6_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
